// File: rtl/axi_lite_ctrl_regs.sv
// AXI-Lite control/status register file for the matrix accelerator: start pulse,
// M/K/N dimensions, busy/done status and a level interrupt.
module axi_lite_ctrl_regs #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CFG_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              start_o,
    output logic [CFG_W-1:0]  cfg_m_o,
    output logic [CFG_W-1:0]  cfg_k_o,
    output logic [CFG_W-1:0]  cfg_n_o,
    input  logic              busy_i,
    input  logic              done_i,
    output logic              irq_o
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_STATUS = 3'd1,
        REG_CFG_M  = 3'd2,
        REG_CFG_K  = 3'd3,
        REG_CFG_N  = 3'd4
    } reg_idx_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel state
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              aw_have_q, aw_have_d;
    logic              w_have_q, w_have_d;
    logic [2:0]        awidx_q, awidx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    // Read channel state
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    // Register file
    logic              ie_q, ie_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CFG_W-1:0]  cfg_m_q, cfg_m_d;
    logic [CFG_W-1:0]  cfg_k_q, cfg_k_d;
    logic [CFG_W-1:0]  cfg_n_q, cfg_n_d;
    logic              start_q, start_d;
    logic              irq_q, irq_d;

    // Handshake and decode helpers
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              commit;
    logic [2:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        wr_resp;
    logic              err_set, err_clr, done_clr;
    logic              cfg_zero;
    logic [DATA_W-1:0] rd_val;
    logic [1:0]        rd_resp;
    logic              unused_bits;

    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, wr_data};

    // Write path: the commit may coincide with either handshake, so the
    // live bus values bypass the holding registers on that edge.
    always_comb begin
        aw_hs    = s_axi_awvalid & awready_q;
        w_hs     = s_axi_wvalid & wready_q;
        b_hs     = bvalid_q & s_axi_bready;
        wr_idx   = aw_hs ? s_axi_awaddr[4:2] : awidx_q;
        wr_data  = w_hs ? s_axi_wdata : wdata_q;
        commit   = (aw_have_q | aw_hs) & (w_have_q | w_hs);
        cfg_zero = (cfg_m_q == '0) | (cfg_k_q == '0) | (cfg_n_q == '0);

        ie_d     = ie_q;
        cfg_m_d  = cfg_m_q;
        cfg_k_d  = cfg_k_q;
        cfg_n_d  = cfg_n_q;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        done_clr = 1'b0;
        start_d  = 1'b0;
        wr_resp  = RESP_OKAY;

        if (commit) begin
            case (wr_idx)
                REG_CTRL: begin
                    ie_d = wr_data[1];
                    if (wr_data[0]) begin
                        if (busy_i || cfg_zero) begin
                            err_set = 1'b1;
                        end else begin
                            start_d = 1'b1;
                        end
                    end
                end
                REG_STATUS: begin
                    done_clr = wr_data[1];
                    err_clr  = wr_data[2];
                end
                REG_CFG_M: begin
                    if (busy_i) wr_resp = RESP_SLVERR;
                    else        cfg_m_d = wr_data[CFG_W-1:0];
                end
                REG_CFG_K: begin
                    if (busy_i) wr_resp = RESP_SLVERR;
                    else        cfg_k_d = wr_data[CFG_W-1:0];
                end
                REG_CFG_N: begin
                    if (busy_i) wr_resp = RESP_SLVERR;
                    else        cfg_n_d = wr_data[CFG_W-1:0];
                end
                default: wr_resp = RESP_SLVERR;
            endcase
        end

        // A done pulse coinciding with a W1C of DONE keeps DONE set
        done_d = done_i | (done_q & ~done_clr);
        err_d  = err_set | (err_q & ~err_clr);
        irq_d  = done_d & ie_d;

        aw_have_d = (aw_have_q | aw_hs) & ~commit;
        w_have_d  = (w_have_q | w_hs) & ~commit;
        awidx_d   = aw_hs ? s_axi_awaddr[4:2] : awidx_q;
        wdata_d   = w_hs ? s_axi_wdata : wdata_q;
        bvalid_d  = commit | (bvalid_q & ~b_hs);
        bresp_d   = commit ? wr_resp : bresp_q;
        awready_d = ~aw_have_d & ~bvalid_d;
        wready_d  = ~w_have_d & ~bvalid_d;
    end

    // Read path
    always_comb begin
        ar_hs   = s_axi_arvalid & arready_q;
        r_hs    = rvalid_q & s_axi_rready;
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (s_axi_araddr[4:2])
            REG_CTRL:   rd_val[1] = ie_q;
            REG_STATUS: rd_val[2:0] = {err_q, done_q, busy_i};
            REG_CFG_M:  rd_val[CFG_W-1:0] = cfg_m_q;
            REG_CFG_K:  rd_val[CFG_W-1:0] = cfg_k_q;
            REG_CFG_N:  rd_val[CFG_W-1:0] = cfg_n_q;
            default:    rd_resp = RESP_SLVERR;
        endcase
        rvalid_d  = ar_hs | (rvalid_q & ~r_hs);
        arready_d = ~rvalid_d;
        rdata_d   = ar_hs ? rd_val : rdata_q;
        rresp_d   = ar_hs ? rd_resp : rresp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cfg_m_q   <= '0;
            cfg_k_q   <= '0;
            cfg_n_q   <= '0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cfg_m_q   <= cfg_m_d;
            cfg_k_q   <= cfg_k_d;
            cfg_n_q   <= cfg_n_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign start_o       = start_q;
    assign cfg_m_o       = cfg_m_q;
    assign cfg_k_o       = cfg_k_q;
    assign cfg_n_o       = cfg_n_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Self-checking bench for axi_lite_ctrl_regs: directed scenarios plus randomized
// register traffic compared against a register-level model.
module tb_axi_lite_ctrl_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_wvalid = 1'b0, s_axi_wready;
    logic [31:0] s_axi_wdata = '0;
    logic        s_axi_bvalid, s_axi_bready = 1'b1;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_rvalid, s_axi_rready = 1'b1;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        start_o;
    logic [15:0] cfg_m_o, cfg_k_o, cfg_n_o;
    logic        busy_i = 1'b0, done_i = 1'b0;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Register-level reference model
    bit          m_ie, m_done, m_err;
    logic [15:0] m_m, m_k, m_n;

    axi_lite_ctrl_regs #(.ADDR_W(32), .DATA_W(32), .CFG_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .start_o(start_o), .cfg_m_o(cfg_m_o), .cfg_k_o(cfg_k_o), .cfg_n_o(cfg_n_o),
        .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_ie = 0; m_done = 0; m_err = 0; m_m = 0; m_k = 0; m_n = 0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input bit busy,
                                        output logic [1:0] resp, output bit start);
        resp = 2'b00;
        start = 0;
        case (a[4:2])
            3'd0: begin
                m_ie = d[1];
                if (d[0]) begin
                    if (busy || m_m == 0 || m_k == 0 || m_n == 0) m_err = 1;
                    else start = 1;
                end
            end
            3'd1: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
            3'd2, 3'd3, 3'd4: begin
                if (busy) resp = 2'b10;
                else if (a[4:2] == 3'd2) m_m = d[15:0];
                else if (a[4:2] == 3'd3) m_k = d[15:0];
                else m_n = d[15:0];
            end
            default: resp = 2'b10;
        endcase
    endfunction

    function automatic void model_read(input logic [31:0] a, input bit busy,
                                       output logic [31:0] d, output logic [1:0] resp);
        d = 0;
        resp = 2'b00;
        case (a[4:2])
            3'd0: d = m_ie ? 32'h2 : 32'h0;
            3'd1: d = {29'd0, m_err, m_done, busy};
            3'd2: d = {16'd0, m_m};
            3'd3: d = {16'd0, m_k};
            3'd4: d = {16'd0, m_n};
            default: resp = 2'b10;
        endcase
    endfunction

    // mode 0: AW and W together; 1: W first, AW after gap; 2: AW first, W after gap.
    // Called and returns at a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int mode, input int gap,
                            output bit ok, output bit on_time, output logic [1:0] resp,
                            output logic start_at_b, output logic start_after, output bit rdy_after);
        int t = 0, w_t = 0, aw_t = 0, n = 0;
        bit aw_done = 0, w_done = 0, early = 0, haw, hw;
        ok = 0; on_time = 0; resp = 2'bxx; start_at_b = 1'bx; start_after = 1'bx; rdy_after = 0;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_awvalid = (mode != 1);
        s_axi_wvalid  = (mode != 2);
        while (!(aw_done && w_done) && t < 40) begin
            if (s_axi_bvalid || start_o) early = 1;
            haw = s_axi_awvalid && s_axi_awready;
            hw  = s_axi_wvalid && s_axi_wready;
            @(posedge clk); @(negedge clk); t++;
            if (haw) begin s_axi_awvalid = 0; aw_done = 1; aw_t = t; end
            if (hw)  begin s_axi_wvalid = 0;  w_done = 1;  w_t = t;  end
            if (mode == 1 && w_done && !aw_done && !s_axi_awvalid && t - w_t >= gap) s_axi_awvalid = 1;
            if (mode == 2 && aw_done && !w_done && !s_axi_wvalid && t - aw_t >= gap) s_axi_wvalid = 1;
        end
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        if (!(aw_done && w_done)) return;
        on_time = (s_axi_bvalid === 1'b1) && !early;
        start_at_b = start_o;
        while (s_axi_bvalid !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        if (s_axi_bvalid !== 1'b1) return;
        resp = s_axi_bresp;
        @(posedge clk); @(negedge clk);
        start_after = start_o;
        rdy_after = (s_axi_awready === 1'b1) && (s_axi_wready === 1'b1) && (s_axi_bvalid === 1'b0);
        ok = 1;
    endtask

    task automatic do_read(input logic [31:0] a, output bit ok, output bit on_time,
                           output logic [31:0] d, output logic [1:0] resp, output bit rdy_after);
        int n = 0;
        ok = 0; on_time = 0; d = 'x; resp = 'x; rdy_after = 0;
        s_axi_araddr = a;
        s_axi_arvalid = 1;
        while (s_axi_arready !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        if (s_axi_arready !== 1'b1) begin s_axi_arvalid = 0; return; end
        @(posedge clk); @(negedge clk);
        s_axi_arvalid = 0;
        on_time = (s_axi_rvalid === 1'b1);
        n = 0;
        while (s_axi_rvalid !== 1'b1 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        if (s_axi_rvalid !== 1'b1) return;
        d = s_axi_rdata;
        resp = s_axi_rresp;
        @(posedge clk); @(negedge clk);
        rdy_after = (s_axi_arready === 1'b1) && (s_axi_rvalid === 1'b0);
        ok = 1;
    endtask

    function automatic logic [90:0] all_outs();
        return {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
                s_axi_rdata, s_axi_rresp, start_o, cfg_m_o, cfg_k_o, cfg_n_o, irq_o};
    endfunction

    task automatic test_reset();
        bit ok, ot, ra;
        logic [31:0] d;
        logic [1:0] r;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_readies: got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        n_checks++;
        if ({s_axi_bvalid, s_axi_rvalid, start_o, irq_o, cfg_m_o, cfg_k_o, cfg_n_o} !== '0) begin
            n_fail++; $display("FAIL reset_others: not all zero after release");
        end
        do_read(32'h0C, ok, ot, d, r, ra);
        n_checks++;
        if (!ok || !ot || d !== 32'h0 || r !== 2'b00) begin
            n_fail++; $display("FAIL reset_read_k: ok=%0b lat=%0b data=%h resp=%b want 0/00", ok, ot, d, r);
        end
    endtask

    task automatic test_write_order();
        bit ok, ot, ra, st;
        logic [1:0] r, er;
        logic sb, sa;
        logic [31:0] d;
        model_write(32'h0C, 32'h5, 0, er, st);
        do_write(32'h0C, 32'h5, 0, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || !ot || r !== er || !ra) begin
            n_fail++; $display("FAIL write_same_cycle: ok=%0b lat=%0b resp=%b rdy=%0b want 1/1/%b/1", ok, ot, r, ra, er);
        end
        model_write(32'h0C, 32'h2, 0, er, st);
        do_write(32'h0C, 32'h2, 1, 3, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || !ot || r !== 2'b00 || !ra) begin
            n_fail++; $display("FAIL write_w_first: ok=%0b lat=%0b resp=%b rdy=%0b want 1/1/00/1", ok, ot, r, ra);
        end
        n_checks++;
        if (cfg_k_o !== 16'd2) begin n_fail++; $display("FAIL cfg_k_out: got %0d want 2", cfg_k_o); end
        do_read(32'h0C, ok, ot, d, r, ra);
        n_checks++;
        if (!ok || !ot || d !== 32'd2 || r !== 2'b00 || !ra) begin
            n_fail++; $display("FAIL read_k: data=%h resp=%b want 2/00", d, r);
        end
    endtask

    task automatic test_start();
        bit ok, ot, ra, st;
        logic [1:0] r, er;
        logic sb, sa;
        logic [31:0] d;
        model_write(32'h08, 32'h2, 0, er, st);
        do_write(32'h08, 32'h2, 2, 1, ok, ot, r, sb, sa, ra);
        model_write(32'h10, 32'h2, 0, er, st);
        do_write(32'h10, 32'h2, 0, 0, ok, ot, r, sb, sa, ra);
        model_write(32'h00, 32'h1, 0, er, st);
        do_write(32'h00, 32'h1, 0, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || !ot || sb !== 1'b1 || sa !== 1'b0 || r !== 2'b00) begin
            n_fail++; $display("FAIL start_pulse: at_b=%b after=%b resp=%b want 1/0/00", sb, sa, r);
        end
        busy_i = 1;
        model_write(32'h00, 32'h1, 1, er, st);
        do_write(32'h00, 32'h1, 0, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || sb !== 1'b0 || sa !== 1'b0 || r !== 2'b00) begin
            n_fail++; $display("FAIL start_busy: at_b=%b after=%b resp=%b want 0/0/00", sb, sa, r);
        end
        do_read(32'h04, ok, ot, d, r, ra);
        n_checks++;
        if (!ok || d !== 32'h5 || r !== 2'b00) begin
            n_fail++; $display("FAIL status_busy_err: data=%h resp=%b want 5/00", d, r);
        end
    endtask

    task automatic test_busy_cfg();
        bit ok, ot, ra, st;
        logic [1:0] r, er;
        logic sb, sa;
        logic [31:0] d;
        model_write(32'h08, 32'h7, 1, er, st);
        do_write(32'h08, 32'h7, 0, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || r !== 2'b10 || cfg_m_o !== 16'd2) begin
            n_fail++; $display("FAIL cfg_while_busy: resp=%b m=%0d want 10/2", r, cfg_m_o);
        end
        busy_i = 0;
        model_write(32'h18, 32'h1234, 0, er, st);
        do_write(32'h18, 32'h1234, 1, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || r !== 2'b10) begin n_fail++; $display("FAIL write_bad_addr: resp=%b want 10", r); end
        do_read(32'h18, ok, ot, d, r, ra);
        n_checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            n_fail++; $display("FAIL read_bad_addr: data=%h resp=%b want 0/10", d, r);
        end
        model_write(32'h04, 32'h4, 0, er, st);
        do_write(32'h04, 32'h4, 0, 0, ok, ot, r, sb, sa, ra);
        do_read(32'h04, ok, ot, d, r, ra);
        n_checks++;
        if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL err_w1c: status=%h want 0", d); end
    endtask

    task automatic test_irq();
        bit ok, ot, ra, st;
        logic [1:0] r, er;
        logic sb, sa;
        logic [31:0] d;
        model_write(32'h00, 32'h2, 0, er, st);
        do_write(32'h00, 32'h2, 0, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq_o); end
        done_i = 1;
        @(posedge clk); @(negedge clk);
        done_i = 0;
        m_done = 1;
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_on_done: got %b want 1", irq_o); end
        // W1C of DONE racing a fresh done pulse
        s_axi_awaddr = 32'h04; s_axi_wdata = 32'h2;
        s_axi_awvalid = 1; s_axi_wvalid = 1; done_i = 1;
        @(posedge clk); @(negedge clk);
        s_axi_awvalid = 0; s_axi_wvalid = 0; done_i = 0;
        n_checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            n_fail++; $display("FAIL race_bvalid: bvalid=%b resp=%b want 1/00", s_axi_bvalid, s_axi_bresp);
        end
        @(posedge clk); @(negedge clk);
        do_read(32'h04, ok, ot, d, r, ra);
        n_checks++;
        if (!ok || d !== 32'h2 || irq_o !== 1'b1) begin
            n_fail++; $display("FAIL done_set_wins: status=%h irq=%b want 2/1", d, irq_o);
        end
        model_write(32'h04, 32'h2, 0, er, st);
        do_write(32'h04, 32'h2, 0, 0, ok, ot, r, sb, sa, ra);
        n_checks++;
        if (!ok || irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b want 0", irq_o); end
    endtask

    task automatic test_backpressure();
        logic [1:0] br, rr;
        logic [31:0] rd;
        bit stable = 1;
        logic [31:0] exp_rd;
        logic [1:0] exp_rr, er;
        bit st;
        model_read(32'h10, 0, exp_rd, exp_rr);
        model_write(32'h10, 32'h3, 0, er, st);
        s_axi_bready = 0; s_axi_rready = 0;
        s_axi_awaddr = 32'h10; s_axi_wdata = 32'h3; s_axi_araddr = 32'h10;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
        @(posedge clk); @(negedge clk);
        br = s_axi_bresp; rr = s_axi_rresp; rd = s_axi_rdata;
        n_checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || rd !== exp_rd || rr !== exp_rr || br !== er) begin
            n_fail++; $display("FAIL bp_first: bv=%b rv=%b rdata=%h rresp=%b bresp=%b want 1/1/%h/%b/%b",
                               s_axi_bvalid, s_axi_rvalid, rd, rr, br, exp_rd, exp_rr, er);
        end
        s_axi_awaddr = 32'h08; s_axi_wdata = 32'h9; s_axi_araddr = 32'h0C;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_bresp !== br || s_axi_rresp !== rr ||
                s_axi_rdata !== rd || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0)
                stable = 0;
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL bp_hold: responses moved or new request accepted (got 0, want 1)"); end
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_bready = 1; s_axi_rready = 1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 5'b00111) begin
            n_fail++; $display("FAIL bp_release: got %b want 00111",
                               {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready});
        end
        n_checks++;
        if (cfg_m_o !== m_m || cfg_n_o !== m_n) begin
            n_fail++; $display("FAIL bp_cfg: m=%0d n=%0d want %0d/%0d", cfg_m_o, cfg_n_o, m_m, m_n);
        end
    endtask

    task automatic test_random();
        bit ok, ot, ra, st, busy;
        logic [1:0] r, er;
        logic sb, sa;
        logic [31:0] a, d, ed;
        int idx;
        for (int it = 0; it < 80; it++) begin
            busy = ($urandom_range(0, 3) == 0);
            busy_i = busy;
            idx = $urandom_range(0, 7);
            a = (idx << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                if ($urandom_range(0, 3) == 0) d[15:0] = 16'h0;
                model_write(a, d, busy, er, st);
                do_write(a, d, $urandom_range(0, 2), $urandom_range(0, 3), ok, ot, r, sb, sa, ra);
                n_checks++;
                if (!ok || !ot || !ra || r !== er || sb !== logic'(st) || sa !== 1'b0) begin
                    n_fail++; $display("FAIL rand_write a=%h d=%h: ok=%0b lat=%0b rdy=%0b resp=%b start=%b/%b want resp=%b start=%0b",
                                       a, d, ok, ot, ra, r, sb, sa, er, st);
                end
                n_checks++;
                if (cfg_m_o !== m_m || cfg_k_o !== m_k || cfg_n_o !== m_n || irq_o !== (m_done & m_ie)) begin
                    n_fail++; $display("FAIL rand_state: m=%h k=%h n=%h irq=%b want %h %h %h %b",
                                       cfg_m_o, cfg_k_o, cfg_n_o, irq_o, m_m, m_k, m_n, m_done & m_ie);
                end
            end else begin
                model_read(a, busy, ed, er);
                do_read(a, ok, ot, d, r, ra);
                n_checks++;
                if (!ok || !ot || !ra || d !== ed || r !== er) begin
                    n_fail++; $display("FAIL rand_read a=%h: data=%h resp=%b want %h/%b", a, d, r, ed, er);
                end
            end
        end
        busy_i = 0;
    endtask

    task automatic test_reset_mid();
        s_axi_awaddr = 32'h08; s_axi_awvalid = 1;
        @(posedge clk); @(negedge clk);
        s_axi_awvalid = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) begin n_fail++; $display("FAIL mid_reset_outs: got %h want 0", all_outs()); end
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        s_axi_wdata = 32'h5; s_axi_wvalid = 1;
        @(posedge clk); @(negedge clk);
        s_axi_wvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s_axi_bvalid !== 1'b0 || cfg_m_o !== 16'd0 || s_axi_awready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_drop: bvalid=%b m=%0d awready=%b want 0/0/1", s_axi_bvalid, cfg_m_o, s_axi_awready);
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_order();
        test_start();
        test_busy_cfg();
        test_irq();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
